// File: rtl/life_grid_engine.sv
// Conway Game of Life engine: serial load, fully parallel generation stepping, non-destructive serial dump.
// Build option LIFE_WRAP_EN: toroidal neighbourhood instead of a dead border.
module life_grid_engine #(
  parameter int ROWS  = 6,
  parameter int COLS  = 6,
  parameter int GEN_W = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start_load,
  input  logic                            load_valid,
  input  logic                            load_bit,
  output logic                            load_ready,
  input  logic                            step_req,
  input  logic [GEN_W-1:0]                step_count,
  input  logic                            dump_req,
  output logic                            out_valid,
  output logic                            out_bit,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done,
  output logic                            stable,
  output logic                            extinct,
  output logic [GEN_W-1:0]                gen_count,
  output logic [$clog2(ROWS*COLS+1)-1:0]  alive_count
);

  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int AW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, LOAD, STEP, DUMP} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     grid_q, grid_d, next_s;
  logic [IW-1:0]    idx_q, idx_d;
  logic [GEN_W-1:0] rem_q, rem_d, gen_q, gen_d;
  logic             stable_q, stable_d, done_q, done_d;
  logic             out_valid_q, out_valid_d, out_bit_q, out_bit_d, out_last_q, out_last_d;
  logic [AW-1:0]    alive_s;

  // Neighbour lookup; the only place the border policy lives.
  function automatic logic [3:0] cell_at(input logic [N-1:0] g, input int r, input int c);
    logic [3:0] v;
`ifdef LIFE_WRAP_EN
    int rr;
    int cc;
    rr = (r + ROWS) % ROWS;
    cc = (c + COLS) % COLS;
    v  = {3'b000, g[IW'(rr * COLS + cc)]};
`else
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) begin
      v = 4'd0;
    end else begin
      v = {3'b000, g[IW'(r * COLS + c)]};
    end
`endif
    return v;
  endfunction

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [3:0] sum_s;
      assign sum_s = cell_at(grid_q, r - 1, c - 1) + cell_at(grid_q, r - 1, c) +
                     cell_at(grid_q, r - 1, c + 1) + cell_at(grid_q, r, c - 1) +
                     cell_at(grid_q, r, c + 1)     + cell_at(grid_q, r + 1, c - 1) +
                     cell_at(grid_q, r + 1, c)     + cell_at(grid_q, r + 1, c + 1);
      assign next_s[r*COLS+c] = (sum_s == 4'd3) || (grid_q[r*COLS+c] && (sum_s == 4'd2));
    end
  end

  // Population count of the current grid.
  always_comb begin
    alive_s = {AW{1'b0}};
    for (int i = 0; i < N; i++) begin
      alive_s = alive_s + AW'(grid_q[i]);
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    grid_d   = grid_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    gen_d    = gen_q;
    stable_d = stable_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = {IW{1'b0}};
        if (start_load) begin
          state_d  = LOAD;
          gen_d    = {GEN_W{1'b0}};
          stable_d = 1'b0;
        end else if (step_req) begin
          state_d  = STEP;
          rem_d    = step_count;
          stable_d = 1'b0;
        end else if (dump_req) begin
          state_d = DUMP;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (load_valid) begin
          grid_d[idx_q] = load_bit;
          if (idx_q == IW'(N - 1)) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          state_d = LOAD;
        end
      end
      STEP: begin
        if (rem_q == {GEN_W{1'b0}}) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          rem_d = rem_q - 1'b1;
          if (gen_q != {GEN_W{1'b1}}) begin
            gen_d = gen_q + 1'b1;
          end else begin
            gen_d = gen_q;
          end
          // A still life is counted as a generation but the grid is left as is.
          if (next_s == grid_q) begin
            stable_d = 1'b1;
            state_d  = IDLE;
            done_d   = 1'b1;
          end else begin
            grid_d = next_s;
            if ((next_s == {N{1'b0}}) || (rem_q == {{(GEN_W-1){1'b0}}, 1'b1})) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = STEP;
            end
          end
        end
      end
      DUMP: begin
        if (idx_q == IW'(N - 1)) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    out_valid_d = (state_d == DUMP);
    out_bit_d   = out_valid_d ? grid_q[idx_d] : 1'b0;
    out_last_d  = out_valid_d && (idx_d == IW'(N - 1));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      grid_q      <= {N{1'b0}};
      idx_q       <= {IW{1'b0}};
      rem_q       <= {GEN_W{1'b0}};
      gen_q       <= {GEN_W{1'b0}};
      stable_q    <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grid_q      <= grid_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      gen_q       <= gen_d;
      stable_q    <= stable_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
    end
  end

  assign load_ready  = (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign stable      = stable_q;
  assign gen_count   = gen_q;
  assign out_valid   = out_valid_q;
  assign out_bit     = out_bit_q;
  assign out_last    = out_last_q;
  assign alive_count = alive_s;
  assign extinct     = (alive_s == {AW{1'b0}});

endmodule

// File: tb/tb_life_grid_engine.sv
// Directed, table-driven bench for life_grid_engine (6x6, GEN_W=8).
module tb_life_grid_engine;

  localparam int N = 36;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_load, load_valid, load_bit, load_ready;
  logic       step_req, dump_req;
  logic [7:0] step_count;
  logic       out_valid, out_bit, out_last, busy, done, stable, extinct;
  logic [7:0] gen_count;
  logic [5:0] alive_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  life_grid_engine #(.ROWS(6), .COLS(6), .GEN_W(8)) dut (
    .clock(clock), .reset(reset),
    .start_load(start_load), .load_valid(load_valid), .load_bit(load_bit), .load_ready(load_ready),
    .step_req(step_req), .step_count(step_count), .dump_req(dump_req),
    .out_valid(out_valid), .out_bit(out_bit), .out_last(out_last),
    .busy(busy), .done(done), .stable(stable), .extinct(extinct),
    .gen_count(gen_count), .alive_count(alive_count)
  );

  localparam logic [35:0] BLINK_H = (36'd1 << 13) | (36'd1 << 14) | (36'd1 << 15);
  localparam logic [35:0] BLINK_V = (36'd1 << 8)  | (36'd1 << 14) | (36'd1 << 20);
  localparam logic [35:0] BLOCK   = (36'd1 << 7)  | (36'd1 << 8)  | (36'd1 << 13) | (36'd1 << 14);
  localparam logic [35:0] SINGLE  = (36'd1 << 21);
  localparam logic [35:0] GLIDER  = (36'd1 << 8)  | (36'd1 << 15) | (36'd1 << 19) | (36'd1 << 20) | (36'd1 << 21);
  localparam logic [35:0] GL_WRAP = (36'd1 << 29) | (36'd1 << 30) | (36'd1 << 4)  | (36'd1 << 5)  | (36'd1 << 0);
  localparam logic [35:0] GL_DEAD = (36'd1 << 28) | (36'd1 << 29) | (36'd1 << 34) | (36'd1 << 35);
  localparam logic [35:0] PAT     = 36'hA5A5A5A5A;
  localparam logic [35:0] LAST1   = 36'h800000000;
  localparam logic [35:0] ALL1    = 36'hFFFFFFFFF;

  typedef struct {
    logic [35:0] init;
    logic [7:0]  steps;
    logic [35:0] exp_grid;
    logic [7:0]  exp_gen;
    logic        exp_stable;
    logic        exp_extinct;
    logic [5:0]  exp_alive;
    int          exp_cycles;
  } vec_t;

  vec_t tv [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_grid(input logic [35:0] p);
    @(negedge clock); start_load = 1'b1;
    @(negedge clock); start_load = 1'b0;
    for (int k = 0; k < N; k++) begin
      load_valid = 1'b1; load_bit = p[k];
      @(negedge clock);
    end
    load_valid = 1'b0; load_bit = 1'b0;
  endtask

  task automatic run_step(input logic [7:0] n, output int cyc, output logic busy_at_done,
                          output logic done_after);
    @(negedge clock); step_req = 1'b1; step_count = n;
    @(negedge clock); step_req = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin
      @(negedge clock); cyc++;
    end
    busy_at_done = busy;
    @(negedge clock);
    done_after = done;
  endtask

  task automatic dump_grid(output logic [35:0] bits, output logic [35:0] valids,
                           output logic [35:0] lasts, output logic [1:0] after);
    @(negedge clock); dump_req = 1'b1;
    @(negedge clock); dump_req = 1'b0;
    for (int k = 0; k < N; k++) begin
      bits[k] = out_bit; valids[k] = out_valid; lasts[k] = out_last;
      @(negedge clock);
    end
    after = {out_valid, busy};
  endtask

  initial begin
    int          cyc;
    logic        b_done, d_after;
    logic [35:0] bits, valids, lasts, bits2;
    logic [1:0]  after;

    reset = 1'b1; start_load = 1'b0; load_valid = 1'b0; load_bit = 1'b0;
    step_req = 1'b0; dump_req = 1'b0; step_count = 8'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_load_ready", 64'(load_ready), 64'd0);
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_out_bit",    64'(out_bit),    64'd0);
    check("rst_out_last",   64'(out_last),   64'd0);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_done",       64'(done),       64'd0);
    check("rst_gen",        64'(gen_count),  64'd0);
    check("rst_stable",     64'(stable),     64'd0);
    check("rst_alive",      64'(alive_count), 64'd0);
    check("rst_extinct",    64'(extinct),    64'd1);

    tv[0] = '{BLINK_H, 8'd1,  BLINK_V, 8'd1, 1'b0, 1'b0, 6'd3, 1};
    tv[1] = '{BLINK_H, 8'd4,  BLINK_H, 8'd4, 1'b0, 1'b0, 6'd3, 4};
    tv[2] = '{BLOCK,   8'd10, BLOCK,   8'd1, 1'b1, 1'b0, 6'd4, 1};
    tv[3] = '{SINGLE,  8'd5,  36'd0,   8'd1, 1'b0, 1'b1, 6'd0, 1};
    tv[4] = '{BLINK_H, 8'd0,  BLINK_H, 8'd0, 1'b0, 1'b0, 6'd3, 1};
`ifdef LIFE_WRAP_EN
    tv[5] = '{GLIDER,  8'd12, GL_WRAP, 8'd12, 1'b0, 1'b0, 6'd5, 12};
`else
    tv[5] = '{GLIDER,  8'd12, GL_DEAD, 8'd12, 1'b1, 1'b0, 6'd4, 12};
`endif

    for (int i = 0; i < 6; i++) begin
      load_grid(tv[i].init);
      check($sformatf("v%0d_gen_after_load", i), 64'(gen_count), 64'd0);
      run_step(tv[i].steps, cyc, b_done, d_after);
      check($sformatf("v%0d_cycles", i),       64'(cyc),         64'(tv[i].exp_cycles));
      check($sformatf("v%0d_busy_at_done", i), 64'(b_done),      64'd0);
      check($sformatf("v%0d_done_pulse", i),   64'(d_after),     64'd0);
      check($sformatf("v%0d_gen", i),          64'(gen_count),   64'(tv[i].exp_gen));
      check($sformatf("v%0d_stable", i),       64'(stable),      64'(tv[i].exp_stable));
      check($sformatf("v%0d_extinct", i),      64'(extinct),     64'(tv[i].exp_extinct));
      check($sformatf("v%0d_alive", i),        64'(alive_count), 64'(tv[i].exp_alive));
      dump_grid(bits, valids, lasts, after);
      check($sformatf("v%0d_grid", i),         64'(bits),        64'(tv[i].exp_grid));
    end

    // Dump is non-destructive and framed correctly.
    load_grid(PAT);
    check("pat_alive", 64'(alive_count), 64'd18);
    dump_grid(bits, valids, lasts, after);
    check("dump1_bits",   64'(bits),   64'(PAT));
    check("dump1_valid",  64'(valids), 64'(ALL1));
    check("dump1_last",   64'(lasts),  64'(LAST1));
    check("dump1_after",  64'(after),  64'd0);
    dump_grid(bits2, valids, lasts, after);
    check("dump2_bits",   64'(bits2),  64'(PAT));
    check("dump2_last",   64'(lasts),  64'(LAST1));

    // Reset in the middle of a dump.
    @(negedge clock); dump_req = 1'b1;
    @(negedge clock); dump_req = 1'b0;
    repeat (10) @(negedge clock);
    check("mid_dump_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check("rst_dump_valid", 64'(out_valid),   64'd0);
    check("rst_dump_busy",  64'(busy),        64'd0);
    check("rst_dump_alive", 64'(alive_count), 64'd0);
    check("rst_dump_last",  64'(out_last),    64'd0);
    reset = 1'b0;

    // Priority, stall, and step_req ignored (not queued) during LOAD.
    @(negedge clock); start_load = 1'b1; step_req = 1'b1; dump_req = 1'b1; step_count = 8'd5;
    @(negedge clock); start_load = 1'b0; dump_req = 1'b0;
    check("prio_load_ready", 64'(load_ready), 64'd1);
    check("prio_no_dump",    64'(out_valid),  64'd0);
    for (int k = 0; k < N; k++) begin
      if (k == 18) begin
        load_valid = 1'b0;
        repeat (5) @(negedge clock);
        check("stall_load_ready", 64'(load_ready), 64'd1);
      end
      load_valid = 1'b1; load_bit = BLINK_H[k];
      @(negedge clock);
    end
    load_valid = 1'b0; step_req = 1'b0;
    check("load_end_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clock);
    check("ignored_step_busy", 64'(busy),      64'd0);
    check("ignored_step_gen",  64'(gen_count), 64'd0);
    dump_grid(bits, valids, lasts, after);
    check("stalled_load_grid", 64'(bits), 64'(BLINK_H));

    // stable clears at the start of the next run.
    load_grid(BLOCK);
    run_step(8'd3, cyc, b_done, d_after);
    check("blk_stable", 64'(stable), 64'd1);
    run_step(8'd0, cyc, b_done, d_after);
    check("blk_stable_clr", 64'(stable),    64'd0);
    check("blk_gen_kept",   64'(gen_count), 64'd1);

    // gen_count saturation.
    load_grid(BLINK_H);
    run_step(8'd255, cyc, b_done, d_after);
    check("sat_cycles", 64'(cyc),       64'd255);
    check("sat_gen",    64'(gen_count), 64'd255);
    run_step(8'd2, cyc, b_done, d_after);
    check("sat_cycles2", 64'(cyc),       64'd2);
    check("sat_gen2",    64'(gen_count), 64'd255);
    dump_grid(bits, valids, lasts, after);
    check("sat_grid",    64'(bits), 64'(BLINK_V));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
